// File: rtl/sorted_drain.sv
// Snapshot-and-drain stage behind the insertion sorter: captures all slots on flush,
// streams valid entries in slot order. Optional duplicate drop: SORTED_DRAIN_DEDUP_EN.

module sorted_drain_slot #(
  parameter int size = 16
) (
  input  logic            clock,
  input  logic            reset_n,
  input  logic            load,
  input  logic            clr,
  input  logic [size-1:0] d_in,
  input  logic            v_in,
  output logic [size-1:0] d,
  output logic            v
);
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) begin
      d <= '0;
      v <= 1'b0;
    end else if (load) begin
      d <= d_in;
      v <= v_in;
    end else if (clr) begin
      v <= 1'b0;
    end
endmodule

module sorted_drain #(
  parameter int blockcount = 16,
  parameter int size       = 16
) (
  input  logic                               clock,
  input  logic                               reset_n,
  input  logic [blockcount-1:0][size-1:0]    slot_data,
  input  logic [blockcount-1:0]              slot_valid,
  input  logic                               flush,
  output logic                               flush_ready,
  output logic                               sorter_clear,
  output logic [size-1:0]                    dataout,
  output logic                               dataout_valid,
  input  logic                               dataout_ready,
  output logic                               dataout_last,
  output logic                               done,
  output logic [$clog2(blockcount+1)-1:0]    count
);
  localparam int IW = (blockcount > 1) ? $clog2(blockcount) : 1;
  localparam int CW = $clog2(blockcount + 1);
  localparam logic [blockcount-1:0] ONE = 1;

  typedef enum logic [1:0] {IDLE, DRAIN, FINISH} state_t;
  state_t state;

  logic [blockcount-1:0][size-1:0] snap;
  logic [blockcount-1:0]           mask, take;
  logic [IW-1:0]                   sel;
  logic [size-1:0]                 cur;
  logic [CW-1:0]                   pop_cnt;
  logic                            accept, any, emit, pop, last;

  assign accept      = flush && (state == IDLE);
  assign flush_ready = (state == IDLE);
  assign done        = (state == FINISH);

  for (genvar g = 0; g < blockcount; g++) begin : g_slot
    sorted_drain_slot #(.size(size)) u_slot (
      .clock(clock), .reset_n(reset_n), .load(accept), .clr(take[g]),
      .d_in(slot_data[g]), .v_in(slot_valid[g]), .d(snap[g]), .v(mask[g])
    );
  end

  // Descending scan so the lowest set bit wins.
  always_comb begin
    sel = '0;
    for (int i = blockcount - 1; i >= 0; i--)
      if (mask[i]) sel = IW'(i);
    pop_cnt = '0;
    for (int i = 0; i < blockcount; i++)
      pop_cnt = pop_cnt + CW'(slot_valid[i]);
  end

  assign cur = snap[sel];
  assign any = |mask;

`ifdef SORTED_DRAIN_DEDUP_EN
  logic [size-1:0] prev;
  logic            have_prev, drop, rest_same;

  // Last emitted entry if every other remaining entry would be dropped as a repeat.
  always_comb begin
    rest_same = 1'b1;
    for (int i = 0; i < blockcount; i++)
      if (mask[i] && (IW'(i) != sel) && (snap[i] != cur)) rest_same = 1'b0;
  end

  assign drop = (state == DRAIN) && any && have_prev && (cur == prev);
  assign emit = (state == DRAIN) && any && !drop;
  assign last = emit && rest_same;
  assign pop  = (emit && dataout_ready) || drop;

  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) begin
      prev      <= '0;
      have_prev <= 1'b0;
    end else if (accept) begin
      have_prev <= 1'b0;
    end else if (emit && dataout_ready) begin
      prev      <= cur;
      have_prev <= 1'b1;
    end
`else
  logic one;
  assign one  = any && ((mask & (mask - ONE)) == '0);
  assign emit = (state == DRAIN) && any;
  assign last = emit && one;
  assign pop  = emit && dataout_ready;
`endif

  assign take          = pop ? (ONE << sel) : '0;
  assign dataout_valid = emit;
  assign dataout       = emit ? cur : '0;
  assign dataout_last  = last;

  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) begin
      state        <= IDLE;
      sorter_clear <= 1'b0;
      count        <= '0;
    end else begin
      sorter_clear <= accept;
      case (state)
        IDLE:    if (flush) begin
                   state <= DRAIN;
                   count <= pop_cnt;
                 end
        DRAIN:   if ((mask & ~take) == '0) state <= FINISH;
        default: state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_sorted_drain.sv
// Directed table-driven bench for sorted_drain plus reset-mid-drain sequence.
module tb_sorted_drain;
  localparam int BC = 16;
  localparam int SZ = 16;

  logic clock = 1'b0, reset_n = 1'b0, flush = 1'b0, dataout_ready = 1'b0;
  logic [BC-1:0][SZ-1:0] slot_data = '0;
  logic [BC-1:0]         slot_valid = '0;
  logic                  flush_ready, sorter_clear, dataout_valid, dataout_last, done;
  logic [SZ-1:0]         dataout;
  logic [4:0]            count;

  sorted_drain #(.blockcount(BC), .size(SZ)) dut (
    .clock(clock), .reset_n(reset_n), .slot_data(slot_data), .slot_valid(slot_valid),
    .flush(flush), .flush_ready(flush_ready), .sorter_clear(sorter_clear),
    .dataout(dataout), .dataout_valid(dataout_valid), .dataout_ready(dataout_ready),
    .dataout_last(dataout_last), .done(done), .count(count)
  );

  always #5 clock = ~clock;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  typedef struct {
    logic [BC-1:0]         valid;
    logic [BC-1:0][SZ-1:0] data;
    logic [15:0]           rdy;      // bit c = ready during cycle T+c
    bit                    hold;     // keep flush high during the drain
    int                    n;
    logic [BC-1:0][SZ-1:0] exp;
    int                    cnt;
    int                    done_cyc;
  } vec_t;

  vec_t vt[7];

  task automatic run(input vec_t v, input int id);
    logic [SZ-1:0] got[$];
    logic [SZ-1:0] pd;
    logic          plast;
    bit            stalled;
    int            done_at, lastpos, nlast, clr_bad, rdy_bad;
    stalled = 0; done_at = -1; lastpos = -1; nlast = 0; clr_bad = 0; rdy_bad = 0;
    pd = '0; plast = 1'b0;
    @(negedge clock);
    slot_data = v.data; slot_valid = v.valid; flush = 1'b1;
    @(posedge clock); #1;
    if (!v.hold) flush = 1'b0;
    slot_data = '1; slot_valid = '1;   // snapshot must not follow the live slots
    for (int c = 1; c <= 40 && done_at < 0; c++) begin
      dataout_ready = v.rdy[c % 16];
      #1;
      if (sorter_clear !== (c == 1)) clr_bad++;
      if (flush_ready !== 1'b0) rdy_bad++;
      if (stalled) begin
        chk($sformatf("v%0d stall data c%0d", id, c), {16'h0, dataout}, {16'h0, pd});
        chk($sformatf("v%0d stall last c%0d", id, c), {31'h0, dataout_last}, {31'h0, plast});
      end
      if (dataout_valid && dataout_ready) begin
        got.push_back(dataout);
        if (dataout_last) begin lastpos = got.size() - 1; nlast++; end
      end
      stalled = dataout_valid && !dataout_ready;
      pd = dataout; plast = dataout_last;
      if (done) begin done_at = c; flush = 1'b0; end
      @(posedge clock); #1;
    end
    chk($sformatf("v%0d done cycle", id), done_at, v.done_cyc);
    chk($sformatf("v%0d count", id), {27'h0, count}, v.cnt);
    chk($sformatf("v%0d n out", id), got.size(), v.n);
    for (int i = 0; i < v.n && i < got.size(); i++)
      chk($sformatf("v%0d out[%0d]", id, i), {16'h0, got[i]}, {16'h0, v.exp[i]});
    chk($sformatf("v%0d last pos", id), lastpos, v.n - 1);
    chk($sformatf("v%0d last cnt", id), nlast, (v.n > 0) ? 1 : 0);
    chk($sformatf("v%0d sorter_clear", id), clr_bad, 0);
    chk($sformatf("v%0d flush_ready busy", id), rdy_bad, 0);
    chk($sformatf("v%0d done pulse", id), {31'h0, done}, 0);
    chk($sformatf("v%0d idle ready", id), {31'h0, flush_ready}, 1);
    slot_valid = '0; slot_data = '0; dataout_ready = 1'b0;
  endtask

  initial begin
    // v0: 3,7,9,12 ready always
    vt[0].valid = 16'h000F; vt[0].data = {BC{16'hDEAD}};
    vt[0].data[0] = 3; vt[0].data[1] = 7; vt[0].data[2] = 9; vt[0].data[3] = 12;
    vt[0].rdy = 16'hFFFF; vt[0].hold = 0; vt[0].n = 4; vt[0].exp = '0;
    vt[0].exp[0] = 3; vt[0].exp[1] = 7; vt[0].exp[2] = 9; vt[0].exp[3] = 12;
    vt[0].cnt = 4; vt[0].done_cyc = 5;
    // v1: same load, ready 1,0,0,1,0,1,1 -> handshakes at c1,c4,c6,c7
    vt[1] = vt[0]; vt[1].rdy = 16'hFFD2; vt[1].done_cyc = 8;
    // v2: empty snapshot
    vt[2].valid = '0; vt[2].data = {BC{16'h1234}}; vt[2].rdy = 16'hFFFF; vt[2].hold = 0;
    vt[2].n = 0; vt[2].exp = '0; vt[2].cnt = 0; vt[2].done_cyc = 2;
    // v3: 0b1010_0001, data = index, flush held through the drain
    vt[3].valid = 16'h00A1; vt[3].rdy = 16'hFFFF; vt[3].hold = 1; vt[3].n = 3;
    for (int i = 0; i < BC; i++) vt[3].data[i] = 16'(i);
    vt[3].exp = '0; vt[3].exp[0] = 0; vt[3].exp[1] = 5; vt[3].exp[2] = 7;
    vt[3].cnt = 3; vt[3].done_cyc = 4;
    // v4: duplicates 4,4,4,8
    vt[4].valid = 16'h000F; vt[4].data = {BC{16'h4444}}; vt[4].rdy = 16'hFFFF; vt[4].hold = 0;
    vt[4].data[0] = 4; vt[4].data[1] = 4; vt[4].data[2] = 4; vt[4].data[3] = 8;
    vt[4].exp = '0; vt[4].cnt = 4; vt[4].done_cyc = 5;
`ifdef SORTED_DRAIN_DEDUP_EN
    vt[4].n = 2; vt[4].exp[0] = 4; vt[4].exp[1] = 8;
`else
    vt[4].n = 4; vt[4].exp[0] = 4; vt[4].exp[1] = 4; vt[4].exp[2] = 4; vt[4].exp[3] = 8;
`endif
    // v5: all slots valid, distinct data
    vt[5].valid = 16'hFFFF; vt[5].rdy = 16'hFFFF; vt[5].hold = 0; vt[5].n = 16;
    for (int i = 0; i < BC; i++) begin
      vt[5].data[i] = 16'(100 + i); vt[5].exp[i] = 16'(100 + i);
    end
    vt[5].cnt = 16; vt[5].done_cyc = 17;
    // v6: only the top slot
    vt[6].valid = 16'h8000; vt[6].data = {BC{16'h0BAD}}; vt[6].data[15] = 16'h5555;
    vt[6].rdy = 16'hFFFF; vt[6].hold = 0; vt[6].n = 1; vt[6].exp = '0;
    vt[6].exp[0] = 16'h5555; vt[6].cnt = 1; vt[6].done_cyc = 2;

    #2;
    chk("rst flush_ready", {31'h0, flush_ready}, 1);
    chk("rst outputs", {27'h0, sorter_clear, dataout_valid, dataout_last, done, 1'b0}, 0);
    chk("rst dataout", {16'h0, dataout}, 0);
    chk("rst count", {27'h0, count}, 0);
    @(negedge clock); reset_n = 1'b1;

    for (int k = 0; k < 7; k++) run(vt[k], k);

    // reset during a 4-entry drain, third entry on the output
    @(negedge clock);
    slot_data = vt[0].data; slot_valid = vt[0].valid; flush = 1'b1; dataout_ready = 1'b1;
    @(posedge clock); #1 flush = 1'b0;
    @(posedge clock); #1;
    @(posedge clock); #1;
    chk("mid pre-reset data", {16'h0, dataout}, 9);
    reset_n = 1'b0; #1;
    chk("mid rst valid", {31'h0, dataout_valid}, 0);
    chk("mid rst dataout", {16'h0, dataout}, 0);
    chk("mid rst last", {31'h0, dataout_last}, 0);
    chk("mid rst count", {27'h0, count}, 0);
    chk("mid rst flush_ready", {31'h0, flush_ready}, 1);
    begin
      int seen_done;
      seen_done = 0;
      for (int c = 0; c < 3; c++) begin
        @(posedge clock); #1;
        if (done) seen_done++;
      end
      @(negedge clock); reset_n = 1'b1;
      for (int c = 0; c < 3; c++) begin
        @(posedge clock); #1;
        if (done || dataout_valid) seen_done++;
      end
      chk("mid no done after reset", seen_done, 0);
    end
    dataout_ready = 1'b0; slot_valid = '0;
    run(vt[0], 7);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end
endmodule
